// File: rtl/regfile_2r1w.sv
// Two-read / one-write LC-3 register file with an integrated N/Z/P condition-code register.
// Optional same-cycle write-to-read forwarding is compiled in with `define REGFILE_BYPASS_EN.
module regfile_2r1w #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned DEPTH = 8,
   parameter int unsigned SEL_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             write_en,
   input  logic [SEL_W-1:0] wr_sel,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             cc_en,
   input  logic [SEL_W-1:0] rd0_sel,
   output logic [WIDTH-1:0] rd0_data,
   input  logic [SEL_W-1:0] rd1_sel,
   output logic [WIDTH-1:0] rd1_data,
   output logic [2:0]       nzp
);

   logic [WIDTH-1:0] r_regs [DEPTH];
   logic [2:0]       r_nzp;
   logic [DEPTH-1:0] w_wr_hit;
   logic             w_wr_ok;
   logic [2:0]       w_cc_next;
   logic [WIDTH-1:0] w_rd0;
   logic [WIDTH-1:0] w_rd1;

   // One-hot write decode; an out-of-range select decodes to no hit at all.
   always_comb begin
      w_wr_hit = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         w_wr_hit[i] = write_en && (wr_sel == SEL_W'(i));
      end
   end

   assign w_wr_ok = |w_wr_hit;

   always_comb begin
      w_cc_next = 3'b001;
      if (wr_data[WIDTH-1]) begin
         w_cc_next = 3'b100;
      end else if (wr_data == '0) begin
         w_cc_next = 3'b010;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            r_regs[i] <= '0;
         end
         r_nzp <= 3'b010;
      end else begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            if (w_wr_hit[i]) begin
               r_regs[i] <= wr_data;
            end
         end
         if (w_wr_ok && cc_en) begin
            r_nzp <= w_cc_next;
         end
      end
   end

   function automatic logic [WIDTH-1:0] f_read(input logic [SEL_W-1:0] sel);
      logic [WIDTH-1:0] v;
      v = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (sel == SEL_W'(i)) begin
            v = r_regs[i];
         end
      end
      return v;
   endfunction

`ifdef REGFILE_BYPASS_EN
   // Forward write data to a matching read port; suppressed while reset is held.
   always_comb begin
      w_rd0 = f_read(rd0_sel);
      w_rd1 = f_read(rd1_sel);
      if (rst_n && w_wr_ok && (wr_sel == rd0_sel)) begin
         w_rd0 = wr_data;
      end
      if (rst_n && w_wr_ok && (wr_sel == rd1_sel)) begin
         w_rd1 = wr_data;
      end
   end
`else
   always_comb begin
      w_rd0 = f_read(rd0_sel);
      w_rd1 = f_read(rd1_sel);
   end
`endif

   assign rd0_data = w_rd0;
   assign rd1_data = w_rd1;
   assign nzp      = r_nzp;

endmodule

// File: tb/tb_regfile_2r1w.sv
// Scoreboard bench for regfile_2r1w: DEPTH=8 and DEPTH=6 instances share stimulus,
// expected values come from an array-based model and are checked by a negedge monitor.
module tb_regfile_2r1w;

   localparam bit BYPASS =
`ifdef REGFILE_BYPASS_EN
      1'b1;
`else
      1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        write_en = 1'b0;
   logic [2:0]  wr_sel = '0;
   logic [15:0] wr_data = '0;
   logic        cc_en = 1'b0;
   logic [2:0]  rd0_sel = '0;
   logic [2:0]  rd1_sel = '0;
   logic [15:0] rd0_a, rd1_a, rd0_b, rd1_b;
   logic [2:0]  nzp_a, nzp_b;

   regfile_2r1w #(.WIDTH(16), .DEPTH(8)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .write_en(write_en), .wr_sel(wr_sel),
      .wr_data(wr_data), .cc_en(cc_en), .rd0_sel(rd0_sel), .rd0_data(rd0_a),
      .rd1_sel(rd1_sel), .rd1_data(rd1_a), .nzp(nzp_a)
   );

   regfile_2r1w #(.WIDTH(16), .DEPTH(6)) u_dut6 (
      .clk(clk), .rst_n(rst_n), .write_en(write_en), .wr_sel(wr_sel),
      .wr_data(wr_data), .cc_en(cc_en), .rd0_sel(rd0_sel), .rd0_data(rd0_b),
      .rd1_sel(rd1_sel), .rd1_data(rd1_b), .nzp(nzp_b)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] r0a;
      logic [15:0] r1a;
      logic [2:0]  na;
      logic [15:0] r0b;
      logic [15:0] r1b;
      logic [2:0]  nb;
      int          id;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   vectors = 0;
   int   miscompares = 0;
   int   step_id = 0;

   // Reference model: index 0 is the DEPTH=8 instance, index 1 the DEPTH=6 instance.
   logic [15:0] m_regs [2][8];
   logic [2:0]  m_nzp [2];
   int          m_depth [2] = '{8, 6};
   bit          m_rst = 1'b1;

   task automatic m_clear();
      for (int d = 0; d < 2; d++) begin
         for (int r = 0; r < 8; r++) m_regs[d][r] = 16'h0000;
         m_nzp[d] = 3'b010;
      end
   endtask

   function automatic logic [15:0] m_read(input int d, input int sel, input bit we,
                                          input int ws, input logic [15:0] wd);
      if (m_rst) return 16'h0000;
      if (BYPASS && we && ws == sel && ws < m_depth[d]) return wd;
      if (sel < m_depth[d]) return m_regs[d][sel];
      return 16'h0000;
   endfunction

   task automatic m_write(input int d, input bit we, input int ws,
                          input logic [15:0] wd, input bit cc);
      if (m_rst || !we || ws >= m_depth[d]) return;
      m_regs[d][ws] = wd;
      if (cc) begin
         if ($signed(wd) < 0)  m_nzp[d] = 3'b100;
         else if (wd == 0)     m_nzp[d] = 3'b010;
         else                  m_nzp[d] = 3'b001;
      end
   endtask

   // Drive one cycle of stimulus (called just after a rising edge), queue the expected view.
   task automatic step(input bit we, input int ws, input logic [15:0] wd, input bit cc,
                       input int r0, input int r1);
      exp_t e;
      write_en = we;
      wr_sel   = 3'(ws);
      wr_data  = wd;
      cc_en    = cc;
      rd0_sel  = 3'(r0);
      rd1_sel  = 3'(r1);
      e.r0a = m_read(0, r0, we, ws, wd);
      e.r1a = m_read(0, r1, we, ws, wd);
      e.na  = m_nzp[0];
      e.r0b = m_read(1, r0, we, ws, wd);
      e.r1b = m_read(1, r1, we, ws, wd);
      e.nb  = m_nzp[1];
      e.id  = step_id;
      step_id++;
      sb.push_back(e);
      @(posedge clk);
      #1;
      m_write(0, we, ws, wd, cc);
      m_write(1, we, ws, wd, cc);
   endtask

   task automatic chk(input string name, input int id, input logic [15:0] act,
                      input logic [15:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s step %0d: got %h expected %h", name, id, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (sb.size() > 0) begin
         mon_e = sb.pop_front();
         chk("rd0_d8", mon_e.id, rd0_a, mon_e.r0a);
         chk("rd1_d8", mon_e.id, rd1_a, mon_e.r1a);
         chk("nzp_d8", mon_e.id, 16'(nzp_a), 16'(mon_e.na));
         chk("rd0_d6", mon_e.id, rd0_b, mon_e.r0b);
         chk("rd1_d6", mon_e.id, rd1_b, mon_e.r1b);
         chk("nzp_d6", mon_e.id, 16'(nzp_b), 16'(mon_e.nb));
      end
   end

   function automatic logic [15:0] rnd_data();
      logic [15:0] v;
      v = 16'($urandom);
      case ($urandom_range(0, 3))
         0:       v = 16'h0000;
         1:       v = v | 16'h8000;
         default: v = v;
      endcase
      return v;
   endfunction

   initial begin
      m_clear();
      m_rst = 1'b1;
      @(posedge clk);
      #1;
      // Held in reset: writes must be ignored and reads return 0.
      step(1, 2, 16'h5555, 1, 2, 0);
      step(1, 3, 16'h8001, 1, 3, 2);
      rst_n = 1'b1;
      m_rst = 1'b0;

      // Dual-port write/read.
      step(1, 1, 16'h0001, 0, 0, 0);
      step(1, 2, 16'h8000, 0, 1, 2);
      step(0, 0, 16'h0000, 0, 1, 2);
      step(0, 0, 16'h0000, 0, 0, 0);

      // Condition codes, then a cc_en=0 write.
      step(1, 6, 16'h8000, 1, 6, 0);
      step(1, 6, 16'h0000, 1, 6, 0);
      step(1, 6, 16'h0005, 1, 6, 0);
      step(1, 6, 16'h8000, 0, 6, 0);
      step(0, 0, 16'h0000, 0, 6, 0);

      // Write-enable gating: R4 untouched, cc_en alone does nothing.
      for (int k = 0; k < 3; k++) step(0, 4, 16'h1234, 1, 4, 4);
      step(0, 4, 16'h8000, 1, 4, 0);

      // Same-cycle read of the register being written.
      step(1, 5, 16'hABCD, 1, 0, 5);
      step(0, 0, 16'h0000, 0, 0, 5);

      // Out-of-range select: ignored by DEPTH=6, a real write for DEPTH=8.
      step(1, 7, 16'h00FF, 1, 7, 7);
      step(0, 0, 16'h0000, 0, 7, 6);
      step(1, 6, 16'h8888, 1, 6, 7);
      step(0, 0, 16'h0000, 0, 6, 7);

      // Asynchronous reset mid-cycle after writing R3.
      step(1, 3, 16'hFFFF, 1, 3, 0);
      step(0, 0, 16'h0000, 0, 3, 3);
      rst_n = 1'b0;
      m_rst = 1'b1;
      m_clear();
      for (int k = 0; k < 8; k++) step(1, $urandom_range(0, 7), rnd_data(), 1, k, 7 - k);
      rst_n = 1'b1;
      m_rst = 1'b0;
      step(0, 0, 16'h0000, 0, 3, 3);

      // Random traffic including back-to-back writes and same-index reads.
      for (int k = 0; k < 400; k++) begin
         step(($urandom_range(0, 3) != 0), $urandom_range(0, 7), rnd_data(),
              $urandom_range(0, 1) == 1, $urandom_range(0, 7), $urandom_range(0, 7));
      end
      step(0, 0, 16'h0000, 0, 0, 0);

      for (int k = 0; k < 10 && sb.size() > 0; k++) @(posedge clk);
      if (sb.size() > 0) begin
         miscompares++;
         $display("FAIL drain: %0d entries left, expected 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
